lcd_ctrl: RTL and testbench

Image-processing controller for an 8×8, 8-bit grayscale image. After reset it loads 64 pixels from an external image ROM into an internal buffer. It then executes single-nibble commands (shift, max/min/average, rotate, mirror) on a 2×2 window around a movable operation point. On a Write command it streams the buffer to an external image RAM and pulses `done`.

---
 rtl/lcd_ctrl_pkg.sv | 18 +
 rtl/lcd_ctrl_win_alu.sv | 37 +++
 rtl/lcd_ctrl.sv | 88 ++++++++
 tb/tb_lcd_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/lcd_ctrl_pkg.sv
// lcd_ctrl_pkg: opcodes, FSM states and image geometry shared by the LCD controller.
package lcd_ctrl_pkg;
  localparam int IMG_W = 8;
  localparam int N_PIX = IMG_W * IMG_W;
  localparam logic [3:0] CMD_WRITE    = 4'd0;
  localparam logic [3:0] CMD_UP       = 4'd1;
  localparam logic [3:0] CMD_DOWN     = 4'd2;
  localparam logic [3:0] CMD_LEFT     = 4'd3;
  localparam logic [3:0] CMD_RIGHT    = 4'd4;
  localparam logic [3:0] CMD_MAX      = 4'd5;
  localparam logic [3:0] CMD_MIN      = 4'd6;
  localparam logic [3:0] CMD_AVG      = 4'd7;
  localparam logic [3:0] CMD_ROT_CCW  = 4'd8;
  localparam logic [3:0] CMD_ROT_CW   = 4'd9;
  localparam logic [3:0] CMD_MIRROR_X = 4'd10;
  localparam logic [3:0] CMD_MIRROR_Y = 4'd11;
  typedef enum logic [2:0] {S_LOAD, S_IDLE, S_EXEC, S_WRITE, S_DONE} state_t;
endpackage

// File: rtl/lcd_ctrl_win_alu.sv
// lcd_ctrl_win_alu: combinational 2x2 window transform (max/min/average/rotate/mirror).
module lcd_ctrl_win_alu
  import lcd_ctrl_pkg::*;
(
  input  logic [3:0] i_op,
  input  logic [7:0] i_tl,
  input  logic [7:0] i_tr,
  input  logic [7:0] i_bl,
  input  logic [7:0] i_br,
  output logic [7:0] o_tl,
  output logic [7:0] o_tr,
  output logic [7:0] o_bl,
  output logic [7:0] o_br
);
  logic [7:0] w_max_t, w_max_b, w_max, w_min_t, w_min_b, w_min;
  logic [9:0] w_sum;
  assign w_max_t = i_tl > i_tr ? i_tl : i_tr;
  assign w_max_b = i_bl > i_br ? i_bl : i_br;
  assign w_max   = w_max_t > w_max_b ? w_max_t : w_max_b;
  assign w_min_t = i_tl < i_tr ? i_tl : i_tr;
  assign w_min_b = i_bl < i_br ? i_bl : i_br;
  assign w_min   = w_min_t < w_min_b ? w_min_t : w_min_b;
  assign w_sum   = 10'(i_tl) + 10'(i_tr) + 10'(i_bl) + 10'(i_br);
  always_comb begin
    {o_tl, o_tr, o_bl, o_br} = {i_tl, i_tr, i_bl, i_br};
    case (i_op)
      CMD_MAX:      {o_tl, o_tr, o_bl, o_br} = {4{w_max}};
      CMD_MIN:      {o_tl, o_tr, o_bl, o_br} = {4{w_min}};
      CMD_AVG:      {o_tl, o_tr, o_bl, o_br} = {4{w_sum[9:2]}};
      CMD_ROT_CCW:  {o_tl, o_tr, o_bl, o_br} = {i_tr, i_br, i_tl, i_bl};
      CMD_ROT_CW:   {o_tl, o_tr, o_bl, o_br} = {i_bl, i_tl, i_br, i_tr};
      CMD_MIRROR_X: {o_tl, o_tr, o_bl, o_br} = {i_bl, i_br, i_tl, i_tr};
      CMD_MIRROR_Y: {o_tl, o_tr, o_bl, o_br} = {i_tr, i_tl, i_br, i_bl};
      default: ;
    endcase
  end
endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: loads an 8x8 image from ROM, applies 2x2 window commands, streams it to RAM.
module lcd_ctrl
  import lcd_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cmd,
  input  logic       cmd_valid,
  output logic       IROM_rd,
  output logic [5:0] IROM_A,
  input  logic [7:0] IROM_Q,
  output logic       IRAM_valid,
  output logic [7:0] IRAM_D,
  output logic [5:0] IRAM_A,
  output logic       busy,
  output logic       done
);
  state_t     r_state, w_next;
  logic [5:0] r_cnt;
  logic [3:0] r_cmd;
  logic [2:0] r_px, r_py, w_xm, w_ym;
  logic [7:0] r_buf [N_PIX];
  logic [5:0] w_a_tl, w_a_tr, w_a_bl, w_a_br;
  logic [7:0] w_tl_n, w_tr_n, w_bl_n, w_br_n;
  // {row, col} concatenation is exactly row*8+col
  assign w_xm   = r_px - 3'd1;
  assign w_ym   = r_py - 3'd1;
  assign w_a_tl = {w_ym, w_xm};
  assign w_a_tr = {w_ym, r_px};
  assign w_a_bl = {r_py, w_xm};
  assign w_a_br = {r_py, r_px};
  lcd_ctrl_win_alu u_alu (
    .i_op (r_cmd),
    .i_tl (r_buf[w_a_tl]),
    .i_tr (r_buf[w_a_tr]),
    .i_bl (r_buf[w_a_bl]),
    .i_br (r_buf[w_a_br]),
    .o_tl (w_tl_n),
    .o_tr (w_tr_n),
    .o_bl (w_bl_n),
    .o_br (w_br_n)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= S_LOAD;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:  w_next = r_cnt == 6'd63 ? S_IDLE : S_LOAD;
      S_IDLE:  w_next = !cmd_valid ? S_IDLE : cmd == CMD_WRITE ? S_WRITE : S_EXEC;
      S_EXEC:  w_next = S_IDLE;
      S_WRITE: w_next = r_cnt == 6'd63 ? S_DONE : S_WRITE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_cnt <= '0;
      r_cmd <= '0;
      r_px  <= 3'd4;
      r_py  <= 3'd4;
    end else begin
      r_cnt <= (r_state == S_LOAD || r_state == S_WRITE) ? r_cnt + 6'd1 : 6'd0;
      if (r_state == S_IDLE && cmd_valid) r_cmd <= cmd;
      if (r_state == S_EXEC) begin
        r_px <= (r_cmd == CMD_LEFT && r_px > 3'd1) ? r_px - 3'd1 :
                (r_cmd == CMD_RIGHT && r_px < 3'd7) ? r_px + 3'd1 : r_px;
        r_py <= (r_cmd == CMD_UP && r_py > 3'd1) ? r_py - 3'd1 :
                (r_cmd == CMD_DOWN && r_py < 3'd7) ? r_py + 3'd1 : r_py;
      end
    end
  // shift opcodes pass through the ALU unchanged, so the window write-back is harmless
  always_ff @(posedge clk)
    if (r_state == S_LOAD) r_buf[r_cnt] <= IROM_Q;
    else if (r_state == S_EXEC) begin
      r_buf[w_a_tl] <= w_tl_n;
      r_buf[w_a_tr] <= w_tr_n;
      r_buf[w_a_bl] <= w_bl_n;
      r_buf[w_a_br] <= w_br_n;
    end
  assign IROM_rd    = r_state == S_LOAD;
  assign IROM_A     = IROM_rd ? r_cnt : 6'd0;
  assign IRAM_valid = r_state == S_WRITE;
  assign IRAM_A     = IRAM_valid ? r_cnt : 6'd0;
  assign IRAM_D     = IRAM_valid ? r_buf[r_cnt] : 8'd0;
  assign busy       = r_state != S_IDLE;
  assign done       = r_state == S_DONE;
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: directed tests of lcd_ctrl against a pixel-array model of the image buffer.
module tb_lcd_ctrl;
  logic clk = 0, reset = 0, cmd_valid = 0;
  logic [3:0] cmd = 0;
  logic IROM_rd, IRAM_valid, busy, done;
  logic [5:0] IROM_A, IRAM_A;
  logic [7:0] IROM_Q = 0, IRAM_D;
  logic [7:0] rom [64];
  logic [7:0] ram [64];
  int m_img [64];
  int m_px = 4, m_py = 4;
  int checks = 0, errors = 0, wr_idx = 0, done_cnt = 0;
  int rot_exp [4][4] = '{'{2, 4, 1, 3}, '{3, 1, 4, 2}, '{3, 4, 1, 2}, '{2, 1, 4, 3}};
  int perm [4][4] = '{'{1, 3, 0, 2}, '{2, 0, 3, 1}, '{2, 3, 0, 1}, '{1, 0, 3, 2}};

  always #5 clk = ~clk;

  lcd_ctrl dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid),
    .IROM_rd(IROM_rd), .IROM_A(IROM_A), .IROM_Q(IROM_Q),
    .IRAM_valid(IRAM_valid), .IRAM_D(IRAM_D), .IRAM_A(IRAM_A),
    .busy(busy), .done(done)
  );

  always @(negedge clk) if (IROM_rd) IROM_Q <= rom[IROM_A];
  always @(negedge clk) if (IRAM_valid) ram[IRAM_A] <= IRAM_D;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", n, act, exp);
    end
  endtask

  // every RAM write must stream the model image in address order
  always @(negedge clk) if (reset) begin
    if (IRAM_valid) begin
      chk("iram_addr", IRAM_A, wr_idx);
      chk("iram_data", IRAM_D, m_img[wr_idx]);
      wr_idx = (wr_idx + 1) % 64;
    end
    if (done) done_cnt++;
  end

  task automatic model_apply(input int op);
    int a[4], v[4], mx, mn, s;
    a[0] = (m_py - 1) * 8 + m_px - 1; a[1] = (m_py - 1) * 8 + m_px;
    a[2] = m_py * 8 + m_px - 1;       a[3] = m_py * 8 + m_px;
    for (int k = 0; k < 4; k++) v[k] = m_img[a[k]];
    mx = v[0]; mn = v[0]; s = 0;
    for (int k = 0; k < 4; k++) begin
      if (v[k] > mx) mx = v[k];
      if (v[k] < mn) mn = v[k];
      s += v[k];
    end
    if (op == 1 && m_py > 1) m_py--;
    if (op == 2 && m_py < 7) m_py++;
    if (op == 3 && m_px > 1) m_px--;
    if (op == 4 && m_px < 7) m_px++;
    for (int k = 0; k < 4; k++) begin
      if (op == 5) m_img[a[k]] = mx;
      if (op == 6) m_img[a[k]] = mn;
      if (op == 7) m_img[a[k]] = s / 4;
      if (op >= 8 && op <= 11) m_img[a[k]] = v[perm[op-8][k]];
    end
  endtask

  task automatic fill_rom(input bit ramp);
    for (int i = 0; i < 64; i++) rom[i] = ramp ? 8'(i) : 8'((i * 37 + 11) % 256);
  endtask

  task automatic set_win(input int tl, input int tr, input int bl, input int br);
    rom[27] = 8'(tl); rom[28] = 8'(tr); rom[35] = 8'(bl); rom[36] = 8'(br);
  endtask

  task automatic do_reset();
    int n;
    @(negedge clk);
    reset = 0;
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    chk("rst_irom_rd", IROM_rd, 1);
    chk("rst_irom_a", IROM_A, 0);
    chk("rst_iram_valid", IRAM_valid, 0);
    chk("rst_iram_a", IRAM_A, 0);
    chk("rst_iram_d", IRAM_D, 0);
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 64; i++) m_img[i] = rom[i];
    m_px = 4; m_py = 4;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (busy && n < 200);
    chk("load_cycles", n, 64);
    chk("load_irom_rd_off", IROM_rd, 0);
    @(negedge clk);
  endtask

  // called at a falling edge with busy low; returns at the falling edge after completion
  task automatic issue(input int op, input bit hold);
    int n, d0;
    if (op == 0) begin
      wr_idx = 0;
      for (int i = 0; i < 64; i++) ram[i] = 0;
    end
    d0 = done_cnt;
    cmd = 4'(op); cmd_valid = 1;
    model_apply(op);
    @(posedge clk); #1;
    cmd_valid = hold;
    chk("accept_busy", busy, 1);
    if (op == 0) begin
      n = 0;
      while (!done && n < 200) begin
        @(posedge clk); #1; n++;
      end
      chk("write_cycles", n, 64);
      chk("done_busy", busy, 1);
      @(posedge clk); #1;
      chk("done_clear", done, 0);
      chk("idle_after_write", busy, 0);
      chk("done_pulses", done_cnt - d0, 1);
    end else begin
      @(posedge clk); #1;
      chk("exec_release", busy, 0);
    end
    @(negedge clk);
  endtask

  task automatic chk_ram();
    for (int i = 0; i < 64; i++) chk("ram_vs_model", ram[i], m_img[i]);
  endtask

  task automatic win_chk(input string n, input int tl, input int tr, input int bl, input int br);
    chk(n, ram[27], tl); chk(n, ram[28], tr); chk(n, ram[35], bl); chk(n, ram[36], br);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    fill_rom(1);
    do_reset();
    issue(0, 0);
    for (int i = 0; i < 64; i++) chk("ramp_copy", ram[i], i);

    fill_rom(0); set_win(10, 20, 30, 40);
    do_reset(); issue(5, 0); issue(0, 0);
    win_chk("max_win", 40, 40, 40, 40); chk_ram();
    do_reset(); issue(6, 0); issue(0, 0);
    win_chk("min_win", 10, 10, 10, 10); chk_ram();
    issue(0, 0);
    win_chk("persist_win", 10, 10, 10, 10);

    set_win(1, 2, 2, 2);
    do_reset(); issue(7, 0); issue(0, 0);
    win_chk("avg_trunc", 1, 1, 1, 1); chk_ram();
    set_win(255, 255, 255, 255);
    do_reset(); issue(7, 0); issue(0, 0);
    win_chk("avg_255", 255, 255, 255, 255); chk_ram();

    for (int op = 8; op <= 11; op++) begin
      set_win(1, 2, 3, 4);
      do_reset(); issue(op, 0); issue(0, 0);
      win_chk($sformatf("rot_mirror_%0d", op), rot_exp[op-8][0], rot_exp[op-8][1],
              rot_exp[op-8][2], rot_exp[op-8][3]);
      chk_ram();
    end

    fill_rom(0);
    do_reset();
    repeat (5) issue(3, 0);
    repeat (5) issue(1, 0);
    chk("model_px_min", m_px, 1); chk("model_py_min", m_py, 1);
    issue(5, 0); issue(0, 0);
    chk("tl_corner_0", ram[0], 88); chk("tl_corner_9", ram[9], 88);
    chk("tl_untouched_2", ram[2], 85); chk("tl_untouched_10", ram[10], 125);
    chk_ram();
    do_reset();
    repeat (5) issue(4, 0);
    repeat (5) issue(2, 0);
    chk("model_px_max", m_px, 7); chk("model_py_max", m_py, 7);
    issue(5, 0); issue(0, 0);
    chk("br_corner_54", ram[54], 254); chk("br_corner_63", ram[63], 254);
    chk("br_untouched_53", ram[53], 180);
    chk_ram();

    // cmd_valid held high from reset onwards; load must ignore it
    cmd = 4'd5; cmd_valid = 1;
    do_reset();
    for (int i = 0; i < 46; i++) begin
      chk("hs_ready", busy, 0);
      issue(i == 45 ? 0 : (i * 7 + 3) % 11 + 1, i != 45);
    end
    chk_ram();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
